// File: rtl/mig_frame_reader.sv
// Reads a frame of 128-bit words from MIG port 0 as burst read commands and streams
// the returned words out through a single register stage.
module mig_frame_reader #(
  parameter int unsigned BURST_WORDS = 32,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic         clk_mif,
  input  logic         rst_n,
  input  logic         ddr_calib_done,
  input  logic         start,
  input  logic [29:0]  base_addr,
  input  logic [19:0]  length_words,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         mig_cmd_en,
  output logic [2:0]   mig_cmd_instr,
  output logic [5:0]   mig_cmd_bl,
  output logic [29:0]  mig_cmd_byte_addr,
  input  logic         mig_cmd_full,
  output logic         mig_rd_en,
  input  logic [127:0] mig_rd_data,
  input  logic         mig_rd_empty,
  input  logic         mig_rd_overflow,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned IW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StDrain, StFin} state_e;

  state_e        state_q, state_d;
  logic [29:0]   addr_q, addr_d;
  logic [19:0]   req_left_q, req_left_d;
  logic [19:0]   rcv_left_q, rcv_left_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          calib_q;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  out_data_q, out_data_d;

  logic [6:0]    burst_n;
  logic          start_ok;
  logic          cmd_fire;
  logic          pop;

  always_comb begin
    burst_n  = (req_left_q < 20'(BURST_WORDS)) ? req_left_q[6:0] : 7'(BURST_WORDS);
    start_ok = (state_q == StIdle) && start && ddr_calib_done;
    // A burst is only issued when the whole burst is guaranteed to fit in the read FIFO.
    cmd_fire = (state_q == StCmd) && !mig_cmd_full &&
               ((32'(inflight_q) + 32'(burst_n)) <= FIFO_DEPTH);
    pop      = !mig_rd_empty && (rcv_left_q != 20'd0) && (!out_valid_q || out_ready);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_left_d  = req_left_q;
    rcv_left_d  = rcv_left_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          if (length_words != 20'd0) begin
            state_d    = StCmd;
            addr_d     = base_addr & ~30'hF;
            req_left_d = length_words;
            rcv_left_d = length_words;
          end else begin
            state_d = StFin;
          end
        end
      end
      StCmd: begin
        if (cmd_fire) begin
          addr_d     = addr_q + {19'd0, burst_n, 4'h0};
          req_left_d = req_left_q - 20'(burst_n);
          if (req_left_q == 20'(burst_n)) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((rcv_left_q == 20'd0) && (!out_valid_q || out_ready)) state_d = StFin;
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (pop) begin
      rcv_left_d  = rcv_left_q - 20'd1;
      out_data_d  = mig_rd_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    inflight_d = inflight_q + (cmd_fire ? IW'(burst_n) : IW'(0)) - (pop ? IW'(1) : IW'(0));

    busy_d = (state_d == StCmd) || (state_d == StDrain);
    done_d = (state_d == StFin);

    error_d = error_q;
    if (start_ok) error_d = 1'b0;
    if (mig_rd_overflow || (calib_q && !ddr_calib_done && busy_q)) error_d = 1'b1;
  end

  always_ff @(posedge clk_mif or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      req_left_q  <= '0;
      rcv_left_q  <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      calib_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_left_q  <= req_left_d;
      rcv_left_q  <= rcv_left_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      calib_q     <= ddr_calib_done;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Command fields are zeroed outside the push cycle so the port is quiet when idle.
  assign mig_cmd_en        = cmd_fire;
  assign mig_cmd_instr     = cmd_fire ? 3'b001 : 3'b000;
  assign mig_cmd_bl        = cmd_fire ? 6'(burst_n - 7'd1) : 6'd0;
  assign mig_cmd_byte_addr = cmd_fire ? addr_q : 30'd0;
  assign mig_rd_en         = pop;

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
